axi_write_arbiter: RTL and testbench

- Round-robin scheduler that shares one `axi_write` engine between `NUM_REQ` write requesters.
- Accepts a command (byte address, length in beats) per requester and picks one pending requester at a time.
- Drives the engine's command port and routes only the granted requester's data stream to the engine.
- Reports per-requester completion; sits between DMA/layer write clients and the AXI write master.

---
 rtl/axi_write_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write engine between NUM_REQ requesters.
// One command is in flight at a time; only the granted requester's stream
// reaches the engine, and only until its last beat.
module axi_write_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int AXI_ADDR_BITWIDTH = 30,
  parameter int AXI_DATA_BITWIDTH = 128,
  parameter int AXI_STRB_BITWIDTH = AXI_DATA_BITWIDTH/8
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*AXI_ADDR_BITWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*AXI_ADDR_BITWIDTH-1:0]   req_len,
  output logic [NUM_REQ-1:0]                     req_done,
  input  logic [NUM_REQ-1:0]                     req_axis_valid,
  output logic [NUM_REQ-1:0]                     req_axis_ready,
  input  logic [NUM_REQ*AXI_DATA_BITWIDTH-1:0]   req_axis_data,
  input  logic [NUM_REQ*AXI_STRB_BITWIDTH-1:0]   req_axis_strb,
  input  logic [NUM_REQ-1:0]                     req_axis_last,
  input  logic                                   eng_cmd_done,
  output logic                                   eng_cmd_start,
  output logic [AXI_ADDR_BITWIDTH-1:0]           eng_cmd_addr,
  output logic [AXI_ADDR_BITWIDTH-1:0]           eng_cmd_len,
  input  logic                                   eng_axis_ready,
  output logic                                   eng_axis_valid,
  output logic [AXI_DATA_BITWIDTH-1:0]           eng_axis_data,
  output logic [AXI_STRB_BITWIDTH-1:0]           eng_axis_strb,
  output logic                                   eng_axis_last,
  output logic [NUM_REQ-1:0]                     arb_grant,
  output logic                                   arb_busy
);

  localparam int IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdxW:0] NumReqW = (IdxW+1)'(NUM_REQ);
  localparam int AW = AXI_ADDR_BITWIDTH;
  localparam int DW = AXI_DATA_BITWIDTH;
  localparam int SW = AXI_STRB_BITWIDTH;

  // state | meaning
  // IDLE  | waiting for a request while the engine reports idle
  // ISSUE | one-cycle command strobe to the engine
  // BUSY  | stream routed from grantee; wait for engine completion
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     last_grant_q, last_grant_d;
  logic [IdxW-1:0]     gidx_q, gidx_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW-1:0]       len_q, len_d;
  logic                stream_open_q, stream_open_d;

  logic                pick_found;
  logic [IdxW-1:0]     pick_idx;
  logic [IdxW:0]       rr_pos;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [AW-1:0]       pick_addr;
  logic [AW-1:0]       pick_len;
  logic                stream_active;

  // Rotating search for the first pending requester after the last owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_pos     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      rr_pos = {1'b0, last_grant_q} + (IdxW+1)'(off);
      if (rr_pos >= NumReqW) rr_pos = rr_pos - NumReqW;
      if (!pick_found && req_valid[rr_pos[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = rr_pos[IdxW-1:0];
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gidx_d        = gidx_q;
    grant_d       = grant_q;
    req_ready_d   = '0;
    req_done_d    = '0;
    addr_d        = addr_q;
    len_d         = len_q;
    stream_open_d = stream_open_q;
    pick_oh       = '0;
    pick_oh[pick_idx] = 1'b1;
    pick_addr     = req_addr[int'(pick_idx)*AW +: AW];
    pick_len      = req_len[int'(pick_idx)*AW +: AW];
    case (state_q)
      IDLE: begin
        // A ready pulse in flight means its requester still shows valid this
        // cycle (zero-length case); skip so it is not granted twice.
        if (pick_found && eng_cmd_done && (req_ready_q == '0)) begin
          req_ready_d = pick_oh;
          addr_d      = pick_addr;
          len_d       = pick_len;
          if (pick_len == '0) begin
            // Never hand the engine a zero length; complete on the spot.
            req_done_d   = pick_oh;
            last_grant_d = pick_idx;
          end else begin
            grant_d = pick_oh;
            gidx_d  = pick_idx;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        stream_open_d = 1'b1;
        state_d       = BUSY;
      end
      BUSY: begin
        if (stream_active && req_axis_valid[gidx_q] && eng_axis_ready &&
            req_axis_last[gidx_q]) begin
          stream_open_d = 1'b0;
        end
        if (eng_cmd_done && !stream_open_q) begin
          req_done_d   = grant_q;
          last_grant_d = gidx_q;
          grant_d      = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= IdxW'(NUM_REQ-1);
      gidx_q        <= '0;
      grant_q       <= '0;
      req_ready_q   <= '0;
      req_done_q    <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      stream_open_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gidx_q        <= gidx_d;
      grant_q       <= grant_d;
      req_ready_q   <= req_ready_d;
      req_done_q    <= req_done_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      stream_open_q <= stream_open_d;
    end
  end

  assign stream_active = (state_q == BUSY) && stream_open_q;

  // Stream mux driven from the registered grant index.
  always_comb begin
    eng_axis_valid = 1'b0;
    eng_axis_data  = '0;
    eng_axis_strb  = '0;
    eng_axis_last  = 1'b0;
    req_axis_ready = '0;
    if (stream_active) begin
      eng_axis_valid         = req_axis_valid[gidx_q];
      eng_axis_data          = req_axis_data[int'(gidx_q)*DW +: DW];
      eng_axis_strb          = req_axis_strb[int'(gidx_q)*SW +: SW];
      eng_axis_last          = req_axis_last[gidx_q];
      req_axis_ready[gidx_q] = eng_axis_ready;
    end
  end

  assign req_ready     = req_ready_q;
  assign req_done      = req_done_q;
  assign eng_cmd_start = (state_q == ISSUE);
  assign eng_cmd_addr  = addr_q;
  assign eng_cmd_len   = len_q;
  assign arb_grant     = grant_q;
  assign arb_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: requester sources, a small engine model and
// scoreboards for commands, beats and completions.
module tb_axi_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 30;
  localparam int DW = 128;
  localparam int SW = DW/8;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*AW-1:0] req_len = '0;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_axis_valid = '0;
  logic [N-1:0]    req_axis_ready;
  logic [N*DW-1:0] req_axis_data = '0;
  logic [N*SW-1:0] req_axis_strb = '0;
  logic [N-1:0]    req_axis_last = '0;
  logic            eng_cmd_done = 1'b1;
  logic            eng_cmd_start;
  logic [AW-1:0]   eng_cmd_addr, eng_cmd_len;
  logic            eng_axis_ready = 1'b1;
  logic            eng_axis_valid;
  logic [DW-1:0]   eng_axis_data;
  logic [SW-1:0]   eng_axis_strb;
  logic            eng_axis_last;
  logic [N-1:0]    arb_grant;
  logic            arb_busy;

  axi_write_arbiter #(.NUM_REQ(N), .AXI_ADDR_BITWIDTH(AW), .AXI_DATA_BITWIDTH(DW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .req_done(req_done), .req_axis_valid(req_axis_valid), .req_axis_ready(req_axis_ready),
    .req_axis_data(req_axis_data), .req_axis_strb(req_axis_strb), .req_axis_last(req_axis_last),
    .eng_cmd_done(eng_cmd_done), .eng_cmd_start(eng_cmd_start), .eng_cmd_addr(eng_cmd_addr),
    .eng_cmd_len(eng_cmd_len), .eng_axis_ready(eng_axis_ready), .eng_axis_valid(eng_axis_valid),
    .eng_axis_data(eng_axis_data), .eng_axis_strb(eng_axis_strb), .eng_axis_last(eng_axis_last),
    .arb_grant(arb_grant), .arb_busy(arb_busy)
  );

  initial forever #5 sys_clk = ~sys_clk;

  typedef struct {int idx; logic [AW-1:0] addr; logic [AW-1:0] len; int post_cyc; bit lat;} cmd_t;
  typedef struct {logic [DW-1:0] d; logic [SW-1:0] s; logic l;} beat_t;

  cmd_t  cmd_q[$];
  beat_t beat_q[$];
  int    done_q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, seq = 0, last_hs_cyc = 0, done_cnt = 0, n_eng_beats = 0, eng_mode = 0;
  int src_n[N], src_idx[N], src_tag[N];
  bit src_extra[N], src_gap[N];
  logic [N-1:0] s_rdy = '0, s_hs = '0;
  logic s_start = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] mk_data(input int i, input int tag, input int k);
    return {32'(i), 32'(tag), 64'(k)};
  endfunction

  function automatic logic [SW-1:0] mk_strb(input int i, input int k);
    return SW'(k*7 + i*3 + 1);
  endfunction

  // Queue a command for requester i; commands must be posted in expected grant order.
  task automatic post(input int i, input logic [AW-1:0] a, input logic [AW-1:0] l,
                      input bit extra, input bit gap, input bit lat);
    cmd_t c;
    beat_t b;
    seq++;
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_len[i*AW +: AW]  = l;
    src_n[i] = int'(l); src_idx[i] = 0; src_extra[i] = extra; src_gap[i] = gap; src_tag[i] = seq;
    c.idx = i; c.addr = a; c.len = l; c.post_cyc = cyc; c.lat = lat;
    cmd_q.push_back(c);
    for (int k = 0; k < int'(l); k++) begin
      b.d = mk_data(i, seq, k); b.s = mk_strb(i, k); b.l = (k == int'(l) - 1);
      beat_q.push_back(b);
    end
    if (l != '0) done_q.push_back(i);
  endtask

  // One clock: update stimulus/engine at the falling edge, then sample and score.
  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    if (s_start) eng_cmd_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) eng_cmd_done = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (s_rdy[i]) req_valid[i] = 1'b0;
      if (s_hs[i]) src_idx[i]++;
      if (src_idx[i] < src_n[i]) begin
        if (!(req_axis_valid[i] && !s_hs[i]))
          req_axis_valid[i] = src_gap[i] ? ($urandom_range(0, 3) != 0) : 1'b1;
        req_axis_last[i] = (src_idx[i] == src_n[i] - 1);
      end else begin
        req_axis_valid[i] = src_extra[i];
        req_axis_last[i]  = 1'b0;
      end
      req_axis_data[i*DW +: DW] = mk_data(i, src_tag[i], src_idx[i]);
      req_axis_strb[i*SW +: SW] = mk_strb(i, src_idx[i]);
    end
    case (eng_mode)
      1: eng_axis_ready = cyc[0];
      2: eng_axis_ready = ($urandom_range(0, 1) == 1);
      default: eng_axis_ready = 1'b1;
    endcase
    #2;
    s_rdy   = req_ready;
    s_start = eng_cmd_start;
    s_hs    = req_axis_valid & req_axis_ready;
    check("oth_rdy", req_axis_ready & ~arb_grant, '0);
    for (int i = 0; i < N; i++)
      if (src_extra[i] && src_idx[i] >= src_n[i] && src_n[i] > 0)
        check("extra_rdy", req_axis_ready[i], 1'b0);
    if (eng_axis_valid && eng_axis_ready) begin
      n_eng_beats++;
      if (beat_q.size() == 0) check("extra_beat", 1'b1, 1'b0);
      else begin
        beat_t b;
        b = beat_q.pop_front();
        check("beat_data", eng_axis_data, b.d);
        check("beat_strb", eng_axis_strb, b.s);
        check("beat_last", eng_axis_last, b.l);
      end
      if (eng_axis_last) begin
        last_hs_cyc = cyc;
        done_cnt = 2;
      end
    end
    if (req_ready != '0) begin
      if (cmd_q.size() == 0) check("unexp_ready", req_ready, '0);
      else begin
        cmd_t c;
        c = cmd_q.pop_front();
        check("ready_vec", req_ready, onehot(c.idx));
        if (c.lat) check("ready_lat", cyc - c.post_cyc, 1);
        if (c.len == '0) begin
          check("zl_done", req_done, onehot(c.idx));
          check("zl_start", eng_cmd_start, 1'b0);
          check("zl_busy", arb_busy, 1'b0);
        end else begin
          check("cmd_start", eng_cmd_start, 1'b1);
          check("cmd_addr", eng_cmd_addr, c.addr);
          check("cmd_len", eng_cmd_len, c.len);
          check("grant", arb_grant, onehot(c.idx));
          check("rdy_nodone", req_done, '0);
        end
      end
    end else if (eng_cmd_start) begin
      check("stray_start", eng_cmd_start, 1'b0);
    end
    if (req_done != '0 && req_ready == '0) begin
      if (done_q.size() == 0) check("unexp_done", req_done, '0);
      else begin
        int g;
        g = done_q.pop_front();
        check("done_vec", req_done, onehot(g));
        check("done_lat", cyc - last_hs_cyc, 3);
        check("done_grant", arb_grant, '0);
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || done_q.size() != 0 || beat_q.size() != 0 || arb_busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain", cmd_q.size() + done_q.size() + beat_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic clear_tb();
    cmd_q.delete(); beat_q.delete(); done_q.delete();
    req_valid = '0; eng_cmd_done = 1'b1; done_cnt = 0; eng_mode = 0;
    s_rdy = '0; s_hs = '0; s_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_n[i] = 0; src_idx[i] = 0; src_extra[i] = 1'b0; src_gap[i] = 1'b0; src_tag[i] = 0;
    end
  endtask

  function automatic logic [127:0] rst_outs();
    return 128'({req_ready, req_done, req_axis_ready, eng_cmd_start, eng_cmd_addr, eng_cmd_len,
                 eng_axis_valid, eng_axis_last, arb_grant, arb_busy});
  endfunction

  initial begin
    int base, n;
    clear_tb();
    #1 sys_rst_n = 1'b0;
    #1 check("reset_outs", rst_outs(), '0);
    tick(); tick();
    sys_rst_n = 1'b1;
    tick();

    // Round-robin from reset: 0, 1, 3, then 0 again.
    post(0, 30'h100, 30'd4, 1'b0, 1'b0, 1'b1);
    post(1, 30'h200, 30'd4, 1'b0, 1'b0, 1'b0);
    post(3, 30'h300, 30'd4, 1'b0, 1'b0, 1'b0);
    wait_drain(300);
    post(0, 30'h140, 30'd4, 1'b0, 1'b0, 1'b1);
    wait_drain(200);

    // Single requester, 16 beats.
    post(2, 30'h1000, 30'd16, 1'b0, 1'b0, 1'b1);
    wait_drain(300);

    // Zero length on req 1, then 0 and 2 together: pointer now favours 2.
    post(1, 30'h2000, 30'd0, 1'b0, 1'b0, 1'b1);
    wait_drain(50);
    post(2, 30'h2100, 30'd2, 1'b0, 1'b0, 1'b0);
    post(0, 30'h2200, 30'd2, 1'b0, 1'b0, 1'b0);
    wait_drain(200);

    // Backpressure with gaps; req 1 precedes req 3 after owner 0.
    eng_mode = 1;
    post(1, 30'h3100, 30'd4, 1'b0, 1'b1, 1'b0);
    post(3, 30'h3000, 30'd8, 1'b0, 1'b1, 1'b0);
    wait_drain(400);
    eng_mode = 2;
    post(0, 30'h3200, 30'd8, 1'b0, 1'b1, 1'b1);
    wait_drain(400);
    eng_mode = 0;

    // Valid held after last.
    post(1, 30'h4000, 30'd4, 1'b1, 1'b0, 1'b1);
    wait_drain(200);
    for (int k = 0; k < 4; k++) tick();
    src_extra[1] = 1'b0;
    tick();

    // Reset during beat 3 of 8.
    post(2, 30'h5000, 30'd8, 1'b0, 1'b0, 1'b1);
    base = n_eng_beats;
    n = 0;
    while (n_eng_beats - base < 2 && n < 100) begin
      tick();
      n++;
    end
    check("pre_reset_beats", n_eng_beats - base, 2);
    #1 sys_rst_n = 1'b0;
    #1 check("midreset_outs", rst_outs(), '0);
    clear_tb();
    tick(); tick();
    check("held_reset_outs", rst_outs(), '0);
    sys_rst_n = 1'b1;
    tick();
    post(0, 30'h6000, 30'd2, 1'b0, 1'b0, 1'b1);
    post(3, 30'h6100, 30'd2, 1'b0, 1'b0, 1'b0);
    wait_drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
